// File: rtl/lcd_pkg.sv
// Shared definitions for the segment-LCD waveform sequencer: bias-level codes,
// common count and frame polarity encoding.
package lcd_pkg;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] V2 = 2'b10;
  localparam logic [1:0] V3 = 2'b11;

  localparam int NCOM = 4;

  typedef enum logic {
    POL_POS = 1'b0,
    POL_NEG = 1'b1
  } pol_t;

endpackage

// File: rtl/lcd_frame_timer.sv
// Phase prescaler, common-phase index and frame polarity for the LCD sequencer.
// Everything is held at zero while disabled so re-enabling starts a fresh frame.
module lcd_frame_timer
  import lcd_pkg::*;
#(
  parameter int DIV = 768,
  parameter int CW  = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  output logic [1:0] ph,
  output pol_t       pol,
  output logic       phase_tick,
  output logic       frame_end
);

  logic [CW-1:0] cnt;

  assign phase_tick = enable && (cnt == CW'(DIV - 1));
  assign frame_end  = phase_tick && (ph == 2'd3) && (pol == POL_NEG);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      ph  <= 2'd0;
      pol <= POL_POS;
    end else if (!enable) begin
      cnt <= '0;
      ph  <= 2'd0;
      pol <= POL_POS;
    end else if (phase_tick) begin
      cnt <= '0;
      ph  <= ph + 2'd1;
      if (ph == 2'd3) begin
        pol <= (pol == POL_POS) ? POL_NEG : POL_POS;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lcd_waveform_gen.sv
// 1/4-duty, 1/3-bias segment LCD sequencer: double-buffered segment image,
// registered 2-bit bias-level codes for every COM and SEG pin.
module lcd_waveform_gen
  import lcd_pkg::*;
#(
  parameter int NSEG = 8,
  parameter int DIV  = 768
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [1:0]          wr_com,
  input  logic [NSEG-1:0]     wr_data,
  input  logic                commit,
  output logic                commit_pending,
  output logic                frame_start,
  output logic [2*NCOM-1:0]   com_voltage,
  output logic [2*NSEG-1:0]   seg_voltage
);

  logic [1:0]      ph;
  pol_t            pol;
  logic            phase_tick;
  logic            frame_end;
  logic            at_phase_start;
  logic [NSEG-1:0] shadow      [NCOM];
  logic [NSEG-1:0] active      [NCOM];
  logic [NSEG-1:0] shadow_next [NCOM];
  logic            apply_commit;
  logic [2*NCOM-1:0] com_next;
  logic [2*NSEG-1:0] seg_next;
  logic            start_next;

  lcd_frame_timer #(.DIV(DIV)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .ph         (ph),
    .pol        (pol),
    .phase_tick (phase_tick),
    .frame_end  (frame_end)
  );

  // The copy takes shadow_next so a write landing on the commit clock is included.
  always_comb begin
    shadow_next = shadow;
    if (wr_en) begin
      shadow_next[wr_com] = wr_data;
    end
  end

  assign apply_commit = (commit || commit_pending) && (!enable || frame_end);
  assign start_next   = enable && at_phase_start && (ph == 2'd0) && (pol == POL_POS);

  always_comb begin
    com_next = '0;
    seg_next = '0;
    if (enable) begin
      for (int k = 0; k < NCOM; k++) begin
        if (pol == POL_POS) begin
          com_next[2*k +: 2] = (ph == 2'(k)) ? V3 : V1;
        end else begin
          com_next[2*k +: 2] = (ph == 2'(k)) ? V0 : V2;
        end
      end
      for (int i = 0; i < NSEG; i++) begin
        if (pol == POL_POS) begin
          seg_next[2*i +: 2] = active[ph][i] ? V0 : V2;
        end else begin
          seg_next[2*i +: 2] = active[ph][i] ? V3 : V1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NCOM; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      commit_pending <= 1'b0;
      at_phase_start <= 1'b1;
      frame_start    <= 1'b0;
      com_voltage    <= '0;
      seg_voltage    <= '0;
    end else begin
      shadow <= shadow_next;
      if (apply_commit) begin
        active <= shadow_next;
      end
      if (apply_commit) begin
        commit_pending <= 1'b0;
      end else if (enable && commit) begin
        commit_pending <= 1'b1;
      end
      at_phase_start <= !enable || phase_tick;
      frame_start    <= start_next;
      com_voltage    <= com_next;
      seg_voltage    <= seg_next;
    end
  end

endmodule

// File: doc/lcd_waveform_gen.md
# lcd_waveform_gen

Multiplexed segment-LCD waveform sequencer for 1/4 duty, 1/3 bias drive. It holds a double-buffered 4 × NSEG segment image and steps through common phases and frame polarities. Each cycle it emits a 2-bit bias-level code for every COM and SEG pin. Each code feeds one downstream 3-clock PWM bias stage, which turns it into 0 V, 1 V, 2 V or 3 V.

## Interface
Parameters:
- NSEG, 8: number of segment pins.
- DIV, 768: clocks per common phase. Must be ≥ 3 and a multiple of 3, so each phase covers whole PWM periods.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  1 = drive waveforms; 0 = all pins at 0 V, sequencer held.
- wr_en  in  1  write shadow row wr_com with wr_data.
- wr_com  in  2  common (row) index for the write.
- wr_data  in  NSEG  segment on-bits for that row; bit i = SEGi.
- commit  in  1  request copy of shadow image to active image.
- commit_pending  out  1  commit accepted, not yet applied.
- frame_start  out  1  1-cycle pulse at the start of every positive-polarity frame.
- com_voltage  out  8  code for COMk in bits [2k+1:2k].
- seg_voltage  out  2·NSEG  code for SEGi in bits [2i+1:2i].

## Operation
- Level codes: 00 = 0 V, 01 = 1 V, 10 = 2 V, 11 = 3 V.
- Sequencer state:
  - prescaler cnt, 0..DIV-1.
  - phase index ph, 0..3 (the selected common).
  - polarity pol: 0 = positive, 1 = negative.
  - A frame is 4 phases, ph 0→3. pol toggles when ph wraps 3→0.
  - The DC-balanced period is 8 phases.
- Positive polarity (pol = 0):
  - Selected COM(ph) = 11; other COMs = 01.
  - SEGi = 00 if active[ph][i] = 1, else 10.
- Negative polarity (pol = 1):
  - Selected COM(ph) = 00; other COMs = 10.
  - SEGi = 11 if on, else 01.
- Resulting pixel bias: on = ±3 V, off = ±1 V.
- Shadow writes:
  - wr_en writes shadow[wr_com] at any time.
  - They never disturb the active image directly.
- Commit while enable = 1:
  - commit sets commit_pending.
  - The copy shadow → active happens at the end of a negative frame (ph = 3, pol = 1, cnt = DIV-1). commit_pending clears in the same cycle.
  - So a new image always starts a positive frame.
- Commit while enable = 0: the copy happens on the next clock; commit_pending stays 0.
- A write and a commit in the same cycle: the write is included in the commit.
- A write after commit but before the boundary: also included, because the copy happens at the boundary.
- commit while already pending: no extra effect.
- enable falling:
  - Next clock: cnt, ph and pol reset to 0, and all outputs go to 00.
  - A pending commit is applied on that clock.
- enable rising: the next clock starts ph = 0, pol = 0, cnt = 0 and pulses frame_start.
- Reset:
  - All outputs 00. commit_pending = 0. frame_start = 0.
  - cnt, ph and pol = 0. Shadow and active images are cleared.

## Timing
- All outputs are registered.
- The codes change on the clock after the cnt = DIV-1 tick, so each phase lasts exactly DIV cycles.
- frame_start is high in the first cycle of ph = 0, pol = 0.
- Reset mid-frame: outputs go to 00 asynchronously; the sequencer restarts from ph = 0 after rstn deasserts and enable = 1.
- Latency:
  - commit → new image visible: ≤ 8·DIV + 1 cycles while enabled.
  - commit while disabled: 1 cycle.

## Structure
- Shared package lcd_pkg holds:
  - V0/V1/V2/V3 code constants.
  - NCOM = 4.
  - The polarity encoding.
- Sub-module lcd_frame_timer holds cnt, ph and pol. It outputs a phase_tick and a frame_end (negative frame end) strobe.
- The top level holds the shadow and active images, the commit logic and the output encoders.

## Test plan
Use NSEG = 8, DIV = 6 for all scenarios.
- Reset with rstn low → com_voltage = 0x00, seg_voltage = 0x0000, commit_pending = 0. Release, set enable = 1 → next cycle frame_start = 1, com_voltage = 0x57, seg_voltage = 0xAAAA.
- Write row 0 = 0x01, then commit mid positive frame:
  - commit_pending = 1 until the negative-frame end.
  - Next positive ph 0 → seg_voltage = 0xAAA8.
  - ph 1 → seg_voltage = 0xAAAA, com_voltage = 0x5D.
- Same image, negative frame, ph 0 → com_voltage = 0xA8, seg_voltage = 0x5557. Phase lengths measure exactly 6 cycles each.
- Commit at cycle T, then write row 1 = 0xFF at T+2 → at the boundary, ph 1 of the positive frame gives seg_voltage = 0x0000.
- Deassert enable mid-phase → next cycle all outputs 0x00. Reassert → restarts at ph 0, pol 0 with frame_start.
- Pulse rstn low mid-frame with pending commit → outputs 0 immediately. commit_pending = 0. Active image is cleared (seg_voltage = 0xAAAA after restart).
